ahb_interconnect: RTL and testbench
===================================

# ahb_interconnect

Parametrised single-master AHB-Lite interconnect: address decoder, slave-select generator and response multiplexer in one block, with a configurable slave count and address map. It sits between the Cortex-M0 bus master and the peripherals. Compared with the fixed decoder plus mux it adds:
- a built-in default slave that returns a two-cycle ERROR on unmapped accesses;
- a per-transfer wait-state watchdog that aborts a hung slave with ERROR;
- sticky capture of the failing address for software diagnosis.

## Interface
Parameters:
- NSLV, 7, number of slaves, 1..8
- BASE, {NSLV{32'h0}}, packed NSLV×32 base addresses; slave i occupies BASE[32i+:32]
- MASK, {NSLV{32'hFFFFF000}}, packed NSLV×32 compare masks
- TIMEOUT, 64, wait-state limit in cycles; 0 disables the watchdog; maximum 65535

Ports:
- HCLK_I  in  1  clock; all state on rising edge
- RESET_I  in  1  asynchronous, active-high reset
- M_HADDR_I  in  32  master address
- M_HTRANS_I  in  2  master transfer type
- M_HREADY_O  out  1  HREADY to master and to all slaves
- M_HRESP_O  out  1  HRESP to master
- M_HRDATA_O  out  32  read data to master
- S_HSEL_O  out  NSLV  one-hot slave select, address phase
- S_HREADY_I  in  NSLV  per-slave HREADYOUT
- S_HRESP_I  in  NSLV  per-slave HRESP
- S_HRDATA_I  in  NSLV×32  packed per-slave read data
- ERR_VALID_O  out  1  sticky flag: an error (decode or timeout) has been captured
- ERR_TIMEOUT_O  out  1  qualifies the captured error: 1 = timeout, 0 = decode
- ERR_ADDR_O  out  32  address of the most recent errored transfer
- ERR_CLR_I  in  1  clears ERR_VALID_O

## Operation
- Decode (combinational):
  - match_i = ((M_HADDR_I & MASK_i) == BASE_i).
  - If several slaves match, the lowest index wins.
  - No match selects the default slave.
  - S_HSEL_O[i] = win_i & M_HTRANS_I[1]. It is all-zero for IDLE/BUSY transfers and for default-slave accesses.
- Address phase is accepted when M_HREADY_O=1 and M_HTRANS_I[1]=1. On acceptance the block registers the data-phase target (slave index or default) and M_HADDR_I.
- State machine:
  - IDLE: no data phase outstanding. M_HREADY_O=1, M_HRESP_O=0, M_HRDATA_O=0.
  - SLV: forwards S_HREADY_I/S_HRESP_I/S_HRDATA_I of the registered slave index.
  - ERR1: M_HREADY_O=0, M_HRESP_O=1.
  - ERR2: M_HREADY_O=1, M_HRESP_O=1.
- Transitions, evaluated whenever M_HREADY_O=1 (IDLE, SLV with slave ready, ERR2):
  - accepted mapped transfer → SLV;
  - accepted unmapped transfer → ERR1;
  - otherwise → IDLE.
- ERR1 always → ERR2.
- Watchdog (TIMEOUT>0):
  - A 16-bit counter increments on every SLV cycle where the selected S_HREADY_I=0.
  - It clears on entry to SLV and on every cycle where the selected S_HREADY_I=1.
  - When the counter reaches TIMEOUT, the next state is ERR1 and the slave response is ignored from then on.
  - Slave recovery is the slave's responsibility.
- Error capture:
  - On entry to ERR1, ERR_ADDR_O is loaded with the registered data-phase address.
  - At the same time ERR_TIMEOUT_O is loaded (1 for a watchdog abort, 0 for a decode error) and ERR_VALID_O is set.
  - ERR_CLR_I clears ERR_VALID_O only. If ERR_CLR_I coincides with a capture, the capture wins.
- A slave returning its own ERROR is forwarded transparently and is not captured.

## Timing
- Reset values: state IDLE, M_HREADY_O=1, M_HRESP_O=0, M_HRDATA_O=0, ERR_VALID_O=0, ERR_TIMEOUT_O=0, ERR_ADDR_O=0, counter=0.
- S_HSEL_O follows the address inputs combinationally and is not affected by reset.
- Reset asserted mid-transfer, including in ERR1/ERR2 or during a watchdog count, returns to IDLE immediately (asynchronously).
- Decode latency: zero cycles, because S_HSEL_O is combinational.
- Data-phase muxing is combinational from the registered index; there is no added wait state for mapped slaves.
- Decode error: master sees exactly 2 data-phase cycles (ERR1, ERR2).
  - A new address phase presented during ERR2 is accepted.
- Timeout: master sees TIMEOUT cycles of slave HREADY=0, then ERR1, then ERR2.
  - Total data phase is TIMEOUT+2 cycles.
- Back-to-back accepted transfers are pipelined: address phase n+1 overlaps data phase n.

## Test plan
- Reset, then IDLE transfers: M_HREADY_O=1, M_HRESP_O=0, S_HSEL_O=0, ERR_VALID_O=0.
- NSLV=3, BASE={0x0,0x10000,0xA0000000}: NONSEQ read to 0x10004 → S_HSEL_O=3'b010. The next cycle M_HRDATA_O equals slave 1's data; a slave-1 wait of 3 cycles gives M_HREADY_O low for exactly those 3 cycles.
- NONSEQ to 0xB0000000 (unmapped) → S_HSEL_O=0, then ERR1 (HREADY=0, HRESP=1), then ERR2 (HREADY=1, HRESP=1). Result: ERR_VALID_O=1, ERR_TIMEOUT_O=0, ERR_ADDR_O=0xB0000000. A back-to-back read to 0x0 issued in ERR2 completes normally.
- TIMEOUT=4, slave 0 holds HREADY low indefinitely → 4 wait cycles, then ERR1/ERR2. Result: ERR_TIMEOUT_O=1, ERR_ADDR_O=faulting address. With TIMEOUT=0 the stall persists for over 100 cycles with no error.
- ERR_CLR_I pulsed in the same cycle as a new decode-error capture → ERR_VALID_O stays 1 and ERR_ADDR_O updates. A later lone ERR_CLR_I → ERR_VALID_O=0 and ERR_ADDR_O unchanged.
- RESET_I asserted in ERR1 and in mid-timeout count → outputs return to reset values within the same cycle. After release, a mapped transfer completes with OKAY.

Source files
------------

// File: rtl/ahb_interconnect.sv
// Single-master AHB-Lite interconnect: address decode, slave select and response mux,
// with a built-in ERROR default slave, a wait-state watchdog and sticky error capture.
module ahb_interconnect #(
  parameter int                 NSLV    = 7,
  parameter logic [NSLV*32-1:0] BASE    = {NSLV{32'h0}},
  parameter logic [NSLV*32-1:0] MASK    = {NSLV{32'hFFFFF000}},
  parameter int                 TIMEOUT = 64
) (
  input  logic              HCLK_I,
  input  logic              RESET_I,
  input  logic [31:0]       M_HADDR_I,
  input  logic [1:0]        M_HTRANS_I,
  output logic              M_HREADY_O,
  output logic              M_HRESP_O,
  output logic [31:0]       M_HRDATA_O,
  output logic [NSLV-1:0]   S_HSEL_O,
  input  logic [NSLV-1:0]   S_HREADY_I,
  input  logic [NSLV-1:0]   S_HRESP_I,
  input  logic [NSLV*32-1:0] S_HRDATA_I,
  output logic              ERR_VALID_O,
  output logic              ERR_TIMEOUT_O,
  output logic [31:0]       ERR_ADDR_O,
  input  logic              ERR_CLR_I
);

  localparam int          IW    = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam bit          WD_EN = (TIMEOUT != 0);
  localparam logic [15:0] TO    = 16'(TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_SLV, ST_ERR1, ST_ERR2} state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   sel_reg, sel_next;
  logic [31:0]     addr_reg, addr_next;
  logic [15:0]     cnt_reg, cnt_next;
  logic            err_valid_reg, err_timeout_reg;
  logic [31:0]     err_addr_reg;

  logic [NSLV-1:0] match;
  logic [NSLV-1:0] win;
  logic            hit;
  logic [IW-1:0]   win_idx;
  logic            accept;
  logic            capture, cap_timeout;
  logic [31:0]     cap_addr;
  logic            sel_ready, sel_resp;
  logic [31:0]     sel_rdata;

  // Lowest-index match has priority when address windows overlap.
  for (genvar gi = 0; gi < NSLV; gi++) begin : g_dec
    assign match[gi] = ((M_HADDR_I & MASK[32*gi +: 32]) == BASE[32*gi +: 32]);
    if (gi == 0) begin : g_first
      assign win[gi] = match[gi];
    end else begin : g_rest
      assign win[gi] = match[gi] & ~(|match[gi-1:0]);
    end
  end

  assign hit      = |match;
  assign S_HSEL_O = win & {NSLV{M_HTRANS_I[1]}};

  always_comb begin
    win_idx = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (match[i]) win_idx = IW'(i);
    end
  end

  always_comb begin
    sel_ready = 1'b1;
    sel_resp  = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel_reg == IW'(i)) begin
        sel_ready = S_HREADY_I[i];
        sel_resp  = S_HRESP_I[i];
        sel_rdata = S_HRDATA_I[32*i +: 32];
      end
    end
  end

  assign accept = M_HREADY_O & M_HTRANS_I[1];

  always_comb begin
    state_next  = state_reg;
    sel_next    = sel_reg;
    addr_next   = addr_reg;
    cnt_next    = cnt_reg;
    capture     = 1'b0;
    cap_timeout = 1'b0;
    cap_addr    = addr_reg;
    M_HREADY_O  = 1'b1;
    M_HRESP_O   = 1'b0;
    M_HRDATA_O  = '0;
    case (state_reg)
      ST_SLV: begin
        M_HREADY_O = sel_ready;
        M_HRESP_O  = sel_resp;
        M_HRDATA_O = sel_rdata;
        if (!sel_ready) begin
          cnt_next = cnt_reg + 16'd1;
          // Abort takes effect on the edge the count reaches the limit.
          if (WD_EN && (cnt_next == TO)) begin
            state_next  = ST_ERR1;
            capture     = 1'b1;
            cap_timeout = 1'b1;
          end
        end else begin
          cnt_next = '0;
        end
      end
      ST_ERR1: begin
        M_HREADY_O = 1'b0;
        M_HRESP_O  = 1'b1;
        state_next = ST_ERR2;
      end
      ST_ERR2: begin
        M_HRESP_O = 1'b1;
      end
      default: ;
    endcase
    if (M_HREADY_O) begin
      if (accept && hit) begin
        state_next = ST_SLV;
        sel_next   = win_idx;
        addr_next  = M_HADDR_I;
        cnt_next   = '0;
      end else if (accept) begin
        state_next  = ST_ERR1;
        addr_next   = M_HADDR_I;
        capture     = 1'b1;
        cap_timeout = 1'b0;
        cap_addr    = M_HADDR_I;
      end else begin
        state_next = ST_IDLE;
      end
    end
  end

  always_ff @(posedge HCLK_I or posedge RESET_I) begin
    if (RESET_I) begin
      state_reg       <= ST_IDLE;
      sel_reg         <= '0;
      addr_reg        <= '0;
      cnt_reg         <= '0;
      err_valid_reg   <= 1'b0;
      err_timeout_reg <= 1'b0;
      err_addr_reg    <= '0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      addr_reg  <= addr_next;
      cnt_reg   <= cnt_next;
      if (capture) begin
        err_valid_reg   <= 1'b1;
        err_timeout_reg <= cap_timeout;
        err_addr_reg    <= cap_addr;
      end else if (ERR_CLR_I) begin
        err_valid_reg <= 1'b0;
      end
    end
  end

  assign ERR_VALID_O   = err_valid_reg;
  assign ERR_TIMEOUT_O = err_timeout_reg;
  assign ERR_ADDR_O    = err_addr_reg;

endmodule

// File: tb/tb_ahb_interconnect.sv
// Directed bench for ahb_interconnect: one DUT with TIMEOUT=4 and a
// watchdog-disabled twin sharing the same stimulus.
module tb_ahb_interconnect;

  localparam int NSLV = 3;
  localparam logic [NSLV*32-1:0] BASE_P = {32'hA000_0000, 32'h0001_0000, 32'h0000_0000};
  localparam logic [NSLV*32-1:0] MASK_P = {NSLV{32'hFFFF_F000}};
  localparam logic [31:0] D0 = 32'hAAAA_5555;
  localparam logic [31:0] D1 = 32'h1111_2222;
  localparam logic [31:0] D2 = 32'hCCCC_0002;

  logic clk;
  logic rst;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [NSLV-1:0] s_hready, s_hresp;
  logic [NSLV*32-1:0] s_hrdata;
  logic err_clr;

  logic hready, hresp, ev, et;
  logic [31:0] rdata, ea;
  logic [NSLV-1:0] hsel;
  logic hready2, hresp2, ev2, et2;
  logic [31:0] rdata2, ea2;
  logic [NSLV-1:0] hsel2;

  int checks = 0;
  int errors = 0;

  ahb_interconnect #(.NSLV(NSLV), .BASE(BASE_P), .MASK(MASK_P), .TIMEOUT(4)) dut (
    .HCLK_I(clk), .RESET_I(rst), .M_HADDR_I(haddr), .M_HTRANS_I(htrans),
    .M_HREADY_O(hready), .M_HRESP_O(hresp), .M_HRDATA_O(rdata), .S_HSEL_O(hsel),
    .S_HREADY_I(s_hready), .S_HRESP_I(s_hresp), .S_HRDATA_I(s_hrdata),
    .ERR_VALID_O(ev), .ERR_TIMEOUT_O(et), .ERR_ADDR_O(ea), .ERR_CLR_I(err_clr)
  );

  ahb_interconnect #(.NSLV(NSLV), .BASE(BASE_P), .MASK(MASK_P), .TIMEOUT(0)) dut_nowd (
    .HCLK_I(clk), .RESET_I(rst), .M_HADDR_I(haddr), .M_HTRANS_I(htrans),
    .M_HREADY_O(hready2), .M_HRESP_O(hresp2), .M_HRDATA_O(rdata2), .S_HSEL_O(hsel2),
    .S_HREADY_I(s_hready), .S_HRESP_I(s_hresp), .S_HRDATA_I(s_hrdata),
    .ERR_VALID_O(ev2), .ERR_TIMEOUT_O(et2), .ERR_ADDR_O(ea2), .ERR_CLR_I(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if ({hready, hresp, rdata, ev, et, ea} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_vals: got rdy=%b resp=%b rdata=%h ev=%b et=%b ea=%h required 1 0 0 0 0 0",
               hready, hresp, rdata, ev, et, ea);
    end
    @(negedge clk);
    rst = 1'b0;
    haddr = 32'h0001_0004;
    htrans = 2'b00;
    #1;
    checks++;
    if ({hready, hresp, hsel, ev} !== {1'b1, 1'b0, 3'b000, 1'b0}) begin
      errors++;
      $display("FAIL idle_xfer: got rdy=%b resp=%b hsel=%b ev=%b required 1 0 000 0", hready, hresp, hsel, ev);
    end
    $display("test_reset done");
  endtask

  task automatic test_mapped_read();
    int low;
    @(negedge clk);
    haddr = 32'h0001_0004;
    htrans = 2'b10;
    #1;
    checks++;
    if (hsel !== 3'b010) begin
      errors++;
      $display("FAIL hsel_slv1: got %b required 010", hsel);
    end
    @(negedge clk);
    htrans = 2'b00;
    #1;
    checks++;
    if ({hready, hresp, rdata} !== {1'b1, 1'b0, D1}) begin
      errors++;
      $display("FAIL read_slv1: got rdy=%b resp=%b rdata=%h required 1 0 %h", hready, hresp, rdata, D1);
    end
    @(negedge clk);
    haddr = 32'h0001_0008;
    htrans = 2'b10;
    low = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      htrans = 2'b00;
      s_hready = 3'b101;
      #1;
      if (!hready) low++;
    end
    @(negedge clk);
    s_hready = 3'b111;
    #1;
    checks++;
    if (low != 3 || hready !== 1'b1 || rdata !== D1) begin
      errors++;
      $display("FAIL wait3: got low_cycles=%0d rdy=%b rdata=%h required 3 1 %h", low, hready, rdata, D1);
    end
    $display("test_mapped_read done");
  endtask

  task automatic test_decode_error();
    @(negedge clk);
    haddr = 32'hB000_0000;
    htrans = 2'b10;
    #1;
    checks++;
    if (hsel !== 3'b000) begin
      errors++;
      $display("FAIL hsel_unmapped: got %b required 000", hsel);
    end
    @(negedge clk);
    htrans = 2'b00;
    #1;
    checks++;
    if ({hready, hresp, ev, et, ea} !== {1'b0, 1'b1, 1'b1, 1'b0, 32'hB000_0000}) begin
      errors++;
      $display("FAIL err1_dec: got rdy=%b resp=%b ev=%b et=%b ea=%h required 0 1 1 0 b0000000",
               hready, hresp, ev, et, ea);
    end
    @(negedge clk);
    haddr = 32'h0000_0000;
    htrans = 2'b10;
    #1;
    checks++;
    if ({hready, hresp, hsel} !== {1'b1, 1'b1, 3'b001}) begin
      errors++;
      $display("FAIL err2_dec: got rdy=%b resp=%b hsel=%b required 1 1 001", hready, hresp, hsel);
    end
    @(negedge clk);
    htrans = 2'b00;
    #1;
    checks++;
    if ({hready, hresp, rdata} !== {1'b1, 1'b0, D0}) begin
      errors++;
      $display("FAIL after_err2: got rdy=%b resp=%b rdata=%h required 1 0 %h", hready, hresp, rdata, D0);
    end
    $display("test_decode_error done");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    haddr = 32'h0001_0004;
    htrans = 2'b10;
    @(negedge clk);
    haddr = 32'h0000_0004;
    #1;
    checks++;
    if ({hready, rdata, hsel} !== {1'b1, D1, 3'b001}) begin
      errors++;
      $display("FAIL b2b_first: got rdy=%b rdata=%h hsel=%b required 1 %h 001", hready, rdata, hsel, D1);
    end
    @(negedge clk);
    htrans = 2'b00;
    #1;
    checks++;
    if ({hready, rdata} !== {1'b1, D0}) begin
      errors++;
      $display("FAIL b2b_second: got rdy=%b rdata=%h required 1 %h", hready, rdata, D0);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_timeout();
    int low, low2;
    @(negedge clk);
    haddr = 32'h0000_0010;
    htrans = 2'b10;
    low = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      htrans = 2'b00;
      s_hready = 3'b110;
      #1;
      if (!hready && !hresp) low++;
    end
    checks++;
    if (low != 4) begin
      errors++;
      $display("FAIL to_waits: got %0d required 4", low);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({hready, hresp, ev, et, ea} !== {1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0010}) begin
      errors++;
      $display("FAIL to_err1: got rdy=%b resp=%b ev=%b et=%b ea=%h required 0 1 1 1 00000010",
               hready, hresp, ev, et, ea);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({hready, hresp} !== 2'b11) begin
      errors++;
      $display("FAIL to_err2: got rdy=%b resp=%b required 1 1", hready, hresp);
    end
    low2 = 6;
    for (int i = 0; i < 110; i++) begin
      @(negedge clk);
      #1;
      if (!hready2) low2++;
    end
    checks++;
    if (low2 != 116 || et2 !== 1'b0) begin
      errors++;
      $display("FAIL nowd_stall: got low_cycles=%0d et=%b required 116 0", low2, et2);
    end
    @(negedge clk);
    s_hready = 3'b111;
    #1;
    checks++;
    if ({hready2, hresp2, rdata2} !== {1'b1, 1'b0, D0}) begin
      errors++;
      $display("FAIL nowd_release: got rdy=%b resp=%b rdata=%h required 1 0 %h", hready2, hresp2, rdata2, D0);
    end
    $display("test_timeout done");
  endtask

  task automatic test_err_clr();
    @(negedge clk);
    haddr = 32'hC000_0000;
    htrans = 2'b10;
    err_clr = 1'b1;
    @(negedge clk);
    htrans = 2'b00;
    err_clr = 1'b0;
    #1;
    checks++;
    if ({ev, et, ea} !== {1'b1, 1'b0, 32'hC000_0000}) begin
      errors++;
      $display("FAIL clr_vs_capture: got ev=%b et=%b ea=%h required 1 0 c0000000", ev, et, ea);
    end
    @(negedge clk);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    checks++;
    if ({ev, ea} !== {1'b0, 32'hC000_0000}) begin
      errors++;
      $display("FAIL lone_clr: got ev=%b ea=%h required 0 c0000000", ev, ea);
    end
    $display("test_err_clr done");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    haddr = 32'hD000_0000;
    htrans = 2'b10;
    @(negedge clk);
    htrans = 2'b00;
    #1;
    checks++;
    if ({hready, hresp, ev} !== 3'b011) begin
      errors++;
      $display("FAIL pre_rst_err1: got rdy=%b resp=%b ev=%b required 0 1 1", hready, hresp, ev);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({hready, hresp, rdata, ev, et, ea} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL rst_in_err1: got rdy=%b resp=%b rdata=%h ev=%b et=%b ea=%h required 1 0 0 0 0 0",
               hready, hresp, rdata, ev, et, ea);
    end
    @(negedge clk);
    rst = 1'b0;
    haddr = 32'h0000_0020;
    htrans = 2'b10;
    @(negedge clk);
    htrans = 2'b00;
    s_hready = 3'b110;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({hready, hresp, rdata} !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL rst_in_count: got rdy=%b resp=%b rdata=%h required 1 0 0", hready, hresp, rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    s_hready = 3'b111;
    haddr = 32'h0001_0004;
    htrans = 2'b10;
    @(negedge clk);
    htrans = 2'b00;
    #1;
    checks++;
    if ({hready, hresp, rdata, ev} !== {1'b1, 1'b0, D1, 1'b0}) begin
      errors++;
      $display("FAIL post_rst_xfer: got rdy=%b resp=%b rdata=%h ev=%b required 1 0 %h 0",
               hready, hresp, rdata, ev, D1);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    rst = 1'b1;
    haddr = '0;
    htrans = 2'b00;
    s_hready = 3'b111;
    s_hresp = 3'b000;
    s_hrdata = {D2, D1, D0};
    err_clr = 1'b0;
    test_reset();
    test_mapped_read();
    test_decode_error();
    test_back_to_back();
    test_timeout();
    test_err_clr();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
